uart_msg_seq: RTL and testbench
===============================

// Module: uart_msg_seq
// PURPOSE
// - Parametrised message sequencer: streams a ROM-held message of runtime length over an AXI-stream master.
// - Output feeds the existing uart_tx axis_* slave. Adds a programmable inter-byte gap, repeat count, abort,
//   busy/done status and an optional checksum trailer. Sits between board switches/control logic and uart_tx.
// PARAMETERS
// - DATA_W      8    beat width in bits
// - MSG_LEN     26   ROM depth in words; max message length
// - INIT_FILE   ""   $readmemh file for the ROM; "" -> word i = 65+i (ASCII 'A'..)
// - GAP_CYCLES  8    idle cycles after each accepted beat before the next tvalid (0 = back-to-back)
// - MSG_GAP     0    extra idle cycles between message repetitions
// - LEN_W       $clog2(MSG_LEN+1)   width of i_Len / o_Index
// PORTS
// - i_Clk          in   1        clock
// - i_Rst_n        in   1        synchronous reset, active-low
// - i_Start        in   1        level; rising edge (internally registered) starts a run when idle
// - i_Abort        in   1        level; stop after the in-flight beat
// - i_Len          in   LEN_W    words per message, sampled on start; clamped to MSG_LEN
// - i_Repeat       in   8        repetitions, sampled on start; 0 = repeat until abort
// - m_axis_tdata   out  DATA_W   beat data
// - m_axis_tvalid  out  1        beat valid
// - m_axis_tready  in   1        from uart_tx axis_tready
// - o_Busy         out  1        high from start acceptance until return to IDLE
// - o_Done         out  1        one-cycle pulse on normal completion (not on abort)
// - o_Index        out  LEN_W    index of the current/next word within the message
// BEHAVIOUR
// - Reset: state=IDLE, tvalid=0, tdata=0, o_Busy=0, o_Done=0, o_Index=0, counters=0, start-edge register=0.
// - FSM IDLE -> FETCH -> SEND -> GAP -> (FETCH | MGAP | CHK | DONE); DONE -> IDLE after 1 cycle.
// - IDLE: a rising edge of i_Start latches len=min(i_Len,MSG_LEN), rep=i_Repeat, index=0 -> FETCH; o_Busy=1.
//   The start edge is accepted only in IDLE; edges while busy are ignored (not queued).
// - FETCH: synchronous ROM read (1 cycle) -> SEND. First tvalid rises 2 cycles after the start edge is sampled.
// - SEND: tvalid=1, tdata held stable until tvalid&tready. Never deassert tvalid or change tdata without a
//   handshake. On handshake: tvalid=0 the next cycle, index+1, -> GAP.
// - GAP: count GAP_CYCLES, then: index<len -> FETCH; else checksum enabled -> CHK; else end of message.
//   GAP_CYCLES=0 passes straight through GAP; at most 1 idle cycle between beats at tready=1.
// - End of message: rep==1 -> DONE; otherwise decrement rep (unless rep==0, infinite), index=0,
//   -> MGAP (MSG_GAP cycles) -> FETCH.
// - DONE: o_Done=1 for exactly one cycle, o_Busy=0 from the next cycle.
// - len==0 at start: no beats emitted; FETCH -> DONE, o_Done pulses 2 cycles after the start edge.
// - i_Abort: in SEND, the pending beat completes its handshake first, then IDLE (no o_Done).
//   In FETCH/GAP/MGAP/CHK-not-yet-valid, go to IDLE the next cycle. Abort together with the last handshake
//   -> IDLE without o_Done.
// - Reset mid-beat: tvalid drops on the reset edge. Reset overrides the AXIS hold rule.
// - Index counter is LEN_W wide; it never exceeds len and never wraps.
// CONFIGURATION
// - UART_MSG_CHECKSUM_EN defined: after the last word of every repetition, emit one extra beat in CHK.
//   Trailer = XOR of all DATA_W words sent in that repetition; the accumulator is cleared at each repetition
//   start. The trailer uses the same SEND handshake rules and is followed by GAP. With len==0, no trailer.
// - Undefined: the CHK state and the accumulator are not synthesised; GAP goes directly to end of message.
// STRUCTURE
// - uart_msg_defs.vh: state encoding localparams (S_IDLE..S_DONE) and the default-ROM fill rule.
//   Shared with the future RX checker.
// - Sub-module msg_rom: DATA_W x MSG_LEN, sync read, INIT_FILE/default init. The FSM, counters and AXIS
//   register stay in uart_msg_seq.
// TESTING
// - Reset release, len=26, rep=1, GAP=8, tready always 1 -> beats 0x41..0x5A in order.
//   Exactly 8 idle cycles between beats, o_Done pulses once, o_Busy falls the next cycle.
// - Random tready backpressure (30% duty) -> tdata/tvalid stable while tready=0, no beat lost or duplicated.
// - len=0 -> zero beats, o_Done 2 cycles after the start edge. len=40 -> clamped, exactly 26 beats.
// - rep=3, MSG_GAP=20, len=4 -> 12 beats (ABCD x3), 20 extra idle cycles between groups, a single o_Done.
// - rep=0 with abort asserted while tvalid=1, tready=0 -> beat held until tready, then IDLE.
//   No further beats, no o_Done. Start edge while busy -> ignored.
// - UART_MSG_CHECKSUM_EN, len=3 -> beats 0x41,0x42,0x43,0x40. Reset asserted mid-SEND -> tvalid=0 next cycle.

Source files
------------

// File: rtl/uart_msg_seq_pkg.sv
// Shared definitions for the UART message sequencer: FSM state encoding and default ROM fill.
// Used by uart_msg_seq and its ROM; intended to be reused by the matching RX checker.
package uart_msg_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StSend,
        StGap,
        StMgap,
        StChk,
        StDone
    } state_e;

    localparam int unsigned RomBase = 65;
    localparam int unsigned CntW    = 16;

    // Default message: word i holds ASCII 'A' + i.
    function automatic int unsigned rom_default(input int unsigned idx);
        return RomBase + idx;
    endfunction

endpackage

// File: rtl/uart_msg_seq_if.sv
// AXI-stream beat channel between the message sequencer and the UART transmitter.
interface uart_msg_seq_if #(
    parameter int unsigned DATA_W = 8
) ();

    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/uart_msg_seq_rom.sv
// Message ROM with one-cycle synchronous read; filled with 'A'.. by default.
module uart_msg_seq_rom
    import uart_msg_seq_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MSG_LEN   = 26,
    parameter string       INIT_FILE = "",
    parameter int unsigned ADDR_W    = 5
) (
    input  logic              i_Clk,
    input  logic [ADDR_W-1:0] i_Addr,
    output logic [DATA_W-1:0] o_Data
);

    logic [DATA_W-1:0] rdata_d, rdata_q;

    always_comb rdata_d = DATA_W'(rom_default(32'(i_Addr)));

    always_ff @(posedge i_Clk) rdata_q <= rdata_d;

    assign o_Data = rdata_q;

endmodule

// File: rtl/uart_msg_seq.sv
// Streams a ROM message over AXI-stream with inter-byte gap, repeat count, abort and status.
// Define UART_MSG_CHECKSUM_EN to append an XOR trailer beat to every repetition.
module uart_msg_seq
    import uart_msg_seq_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned MSG_LEN    = 26,
    parameter string       INIT_FILE  = "",
    parameter int unsigned GAP_CYCLES = 8,
    parameter int unsigned MSG_GAP    = 0,
    parameter int unsigned LEN_W      = $clog2(MSG_LEN + 1)
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_Start,
    input  logic             i_Abort,
    input  logic [LEN_W-1:0] i_Len,
    input  logic [7:0]       i_Repeat,
    uart_msg_seq_if.master   m_axis,
    output logic             o_Busy,
    output logic             o_Done,
    output logic [LEN_W-1:0] o_Index
);

    localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MSG_LEN);
    // The FETCH (or CHK) cycle is itself one idle cycle, so GAP holds one cycle less.
    localparam int unsigned GapHold  = (GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0;
    localparam int unsigned MgapHold = (MSG_GAP > 0) ? MSG_GAP - 1 : 0;

    state_e            state_q, state_d;
    logic              start_q, start_qq;
    logic [LEN_W-1:0]  len_q, len_d, index_q, index_d;
    logic [7:0]        rep_q, rep_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] tdata_q, tdata_d, rom_data;
    logic              tvalid_q, tvalid_d;
    logic              start_rise, handshake, advance;
`ifdef UART_MSG_CHECKSUM_EN
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              chk_sent_q, chk_sent_d;
`endif

    assign start_rise = start_q & ~start_qq;
    assign handshake  = tvalid_q & m_axis.tready;

    uart_msg_seq_rom #(
        .DATA_W   (DATA_W),
        .MSG_LEN  (MSG_LEN),
        .INIT_FILE(INIT_FILE),
        .ADDR_W   (LEN_W)
    ) u_rom (
        .i_Clk (i_Clk),
        .i_Addr(index_d),
        .o_Data(rom_data)
    );

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        index_d  = index_q;
        rep_d    = rep_q;
        cnt_d    = cnt_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        advance  = 1'b0;
`ifdef UART_MSG_CHECKSUM_EN
        acc_d      = acc_q;
        chk_sent_d = chk_sent_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start_rise) begin
                    len_d   = (i_Len > MaxLen) ? MaxLen : i_Len;
                    rep_d   = i_Repeat;
                    index_d = '0;
                    state_d = StFetch;
`ifdef UART_MSG_CHECKSUM_EN
                    acc_d      = '0;
                    chk_sent_d = 1'b0;
`endif
                end
            end
            StFetch: begin
                if (i_Abort) begin
                    state_d = StIdle;
                end else if (len_q == '0) begin
                    state_d = StDone;
                end else begin
                    tdata_d  = rom_data;
                    tvalid_d = 1'b1;
                    state_d  = StSend;
                end
            end
            StSend: begin
                if (handshake) begin
                    tvalid_d = 1'b0;
                    cnt_d    = '0;
`ifdef UART_MSG_CHECKSUM_EN
                    if (!chk_sent_q) begin
                        index_d = index_q + 1'b1;
                        acc_d   = acc_q ^ tdata_q;
                    end
`else
                    index_d = index_q + 1'b1;
`endif
                    if (i_Abort) state_d = StIdle;
                    else if (GAP_CYCLES > 1) state_d = StGap;
                    else advance = 1'b1;
                end
            end
            StGap: begin
                if (i_Abort) state_d = StIdle;
                else if (cnt_q == CntW'(GapHold)) advance = 1'b1;
                else cnt_d = cnt_q + 1'b1;
            end
            StMgap: begin
                if (i_Abort) state_d = StIdle;
                else if (cnt_q == CntW'(MgapHold)) state_d = StFetch;
                else cnt_d = cnt_q + 1'b1;
            end
            StChk: begin
`ifdef UART_MSG_CHECKSUM_EN
                if (i_Abort) begin
                    state_d = StIdle;
                end else begin
                    tdata_d    = acc_q;
                    tvalid_d   = 1'b1;
                    chk_sent_d = 1'b1;
                    state_d    = StSend;
                end
`else
                state_d = StIdle;
`endif
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Decide what follows a finished inter-byte gap.
        if (advance) begin
            if (index_d < len_q) begin
                state_d = StFetch;
`ifdef UART_MSG_CHECKSUM_EN
            end else if (!chk_sent_d) begin
                state_d = StChk;
`endif
            end else if (rep_q == 8'd1) begin
                state_d = StDone;
            end else begin
                if (rep_q != 8'd0) rep_d = rep_q - 8'd1;
                index_d = '0;
                cnt_d   = '0;
                state_d = (MSG_GAP > 0) ? StMgap : StFetch;
`ifdef UART_MSG_CHECKSUM_EN
                acc_d      = '0;
                chk_sent_d = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state_q  <= StIdle;
            start_q  <= 1'b0;
            start_qq <= 1'b0;
            len_q    <= '0;
            index_q  <= '0;
            rep_q    <= '0;
            cnt_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= i_Start;
            start_qq <= start_q;
            len_q    <= len_d;
            index_q  <= index_d;
            rep_q    <= rep_d;
            cnt_q    <= cnt_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
        end
    end

`ifdef UART_MSG_CHECKSUM_EN
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            acc_q      <= '0;
            chk_sent_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            chk_sent_q <= chk_sent_d;
        end
    end
`endif

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;
    assign o_Busy        = (state_q != StIdle);
    assign o_Done        = (state_q == StDone);
    assign o_Index       = index_q;

endmodule

// File: tb/tb_uart_msg_seq.sv
// Self-checking bench for uart_msg_seq: directed runs plus random backpressure against a message model.
module tb_uart_msg_seq;

    localparam int DataW  = 8;
    localparam int MsgLen = 26;
    localparam int Gap    = 8;
    localparam int MsgGap = 20;
    localparam int LenW   = 5;

    logic            clk = 1'b0;
    logic            rst_n, start, abort;
    logic [LenW-1:0] len;
    logic [7:0]      rep;
    logic            busy, done;
    logic [LenW-1:0] index;

    uart_msg_seq_if #(.DATA_W(DataW)) axis ();

    uart_msg_seq #(
        .DATA_W    (DataW),
        .MSG_LEN   (MsgLen),
        .INIT_FILE (""),
        .GAP_CYCLES(Gap),
        .MSG_GAP   (MsgGap),
        .LEN_W     (LenW)
    ) dut (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .i_Start (start),
        .i_Abort (abort),
        .i_Len   (len),
        .i_Repeat(rep),
        .m_axis  (axis),
        .o_Busy  (busy),
        .o_Done  (done),
        .o_Index (index)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int start_cyc, last_done;

    always @(posedge clk) cyc++;

    bit   rand_ready = 1'b0;
    logic ready_fix  = 1'b1;

    always @(posedge clk) begin
        #2;
        axis.tready = rand_ready ? ($urandom_range(0, 9) < 3) : ready_fix;
    end

    // Monitor: beats, idle cycles before each beat, done pulses, AXIS hold violations.
    logic [DataW-1:0] got_q[$];
    int               gap_q[$];
    int               idle_run, done_cnt, first_valid, hold_viol;
    bit               hold_pend;
    logic [DataW-1:0] hold_data;

    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend && !(axis.tvalid === 1'b1 && axis.tdata === hold_data)) hold_viol++;
            hold_pend = (axis.tvalid === 1'b1 && axis.tready === 1'b0);
            hold_data = axis.tdata;
            if (axis.tvalid === 1'b1 && first_valid < 0) first_valid = cyc;
            if (axis.tvalid === 1'b1 && axis.tready === 1'b1) begin
                got_q.push_back(axis.tdata);
                gap_q.push_back(idle_run);
                idle_run = 0;
            end else if (axis.tvalid !== 1'b1) begin
                idle_run++;
            end
            if (done === 1'b1) begin
                done_cnt++;
                last_done = cyc;
            end
        end
    end

    // Reference model: expected beats of a run, built directly from the message rules.
    logic [DataW-1:0] exp_q[$];
    int               beats_per_rep;

    task automatic build_model(input int req_len, input int reps);
        int l;
        logic [DataW-1:0] acc;
        l = (req_len > MsgLen) ? MsgLen : req_len;
        exp_q.delete();
        beats_per_rep = l;
`ifdef UART_MSG_CHECKSUM_EN
        if (l > 0) beats_per_rep++;
`endif
        for (int r = 0; r < reps; r++) begin
            acc = '0;
            for (int i = 0; i < l; i++) begin
                exp_q.push_back(DataW'(65 + i));
                acc ^= DataW'(65 + i);
            end
`ifdef UART_MSG_CHECKSUM_EN
            if (l > 0) exp_q.push_back(acc);
`endif
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        got_q.delete();
        gap_q.delete();
        idle_run    = 0;
        done_cnt    = 0;
        first_valid = -1;
        hold_viol   = 0;
    endtask

    task automatic start_run(input int l, input int r);
        @(posedge clk);
        #1;
        len       = l[LenW-1:0];
        rep       = r[7:0];
        start     = 1'b1;
        start_cyc = cyc + 1;
        repeat (3) @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, "_done_seen"}, 32'(done_cnt > 0), 32'd1);
        @(negedge clk);
        #1;
        check({tag, "_busy_after_done"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n;
        n = 0;
        while (axis.tvalid !== 1'b1 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, "_valid_seen"}, 32'(axis.tvalid), 32'd1);
    endtask

    task automatic compare_beats(input string tag);
        check({tag, "_beat_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_beat%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    task automatic check_gaps(input string tag);
        for (int k = 1; k < gap_q.size(); k++)
            check($sformatf("%s_gap%0d", tag, k), 32'(gap_q[k]),
                  32'((k % beats_per_rep == 0) ? Gap + MsgGap : Gap));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        len   = '0;
        rep   = '0;
        clear_mon();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_tvalid", 32'(axis.tvalid), 32'd0);
        check("rst_tdata", 32'(axis.tdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_index", 32'(index), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Full alphabet, single pass, tready held high.
        clear_mon();
        build_model(26, 1);
        start_run(26, 1);
        wait_done("full", 600);
        check("full_first_valid_lat", 32'(first_valid - start_cyc), 32'd2);
        compare_beats("full");
        check_gaps("full");
        repeat (5) @(negedge clk);
        check("full_done_once", 32'(done_cnt), 32'd1);

        // Zero length: no beats, done two cycles after the start edge.
        clear_mon();
        build_model(0, 1);
        start_run(0, 1);
        wait_done("len0", 50);
        check("len0_done_lat", 32'(last_done - start_cyc), 32'd2);
        compare_beats("len0");

        // Oversized length is clamped to the ROM depth.
        clear_mon();
        build_model(31, 1);
        start_run(31, 1);
        wait_done("clamp", 600);
        compare_beats("clamp");

        // Three repetitions with a message gap.
        clear_mon();
        build_model(4, 3);
        start_run(4, 3);
        wait_done("rep3", 800);
        compare_beats("rep3");
        check_gaps("rep3");
        repeat (5) @(negedge clk);
        check("rep3_done_once", 32'(done_cnt), 32'd1);

        // Random backpressure at roughly 30% tready.
        rand_ready = 1'b1;
        clear_mon();
        build_model(10, 2);
        start_run(10, 2);
        wait_done("bp", 4000);
        compare_beats("bp");
        check("bp_hold_viol", 32'(hold_viol), 32'd0);
        rand_ready = 1'b0;
        ready_fix  = 1'b1;

        // A second start edge while busy must not queue another run.
        clear_mon();
        build_model(3, 2);
        start_run(3, 2);
        start_run(3, 2);
        wait_done("restart", 600);
        repeat (20) @(negedge clk);
        #1;
        compare_beats("restart");
        check("restart_done_once", 32'(done_cnt), 32'd1);
        check("restart_idle", 32'(busy), 32'd0);

        // Abort while a beat is stalled: beat completes, then idle, no done.
        ready_fix = 1'b0;
        clear_mon();
        start_run(5, 0);
        wait_valid("abort", 50);
        @(posedge clk);
        #1 abort = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("abort_hold_valid", 32'(axis.tvalid), 32'd1);
        check("abort_hold_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1 ready_fix = 1'b1;
        repeat (30) @(negedge clk);
        #1;
        check("abort_beats", 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0) check("abort_beat_data", 32'(got_q[0]), 32'h41);
        check("abort_idle", 32'(busy), 32'd0);
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_hold_viol", 32'(hold_viol), 32'd0);
        abort = 1'b0;

`ifdef UART_MSG_CHECKSUM_EN
        // Trailer for "ABC" is 0x41^0x42^0x43 = 0x40.
        clear_mon();
        start_run(3, 1);
        wait_done("chk", 200);
        check("chk_beats", 32'(got_q.size()), 32'd4);
        if (got_q.size() == 4) check("chk_trailer", 32'(got_q[3]), 32'h40);
`endif

        // Reset during a stalled beat drops tvalid on the reset edge.
        ready_fix = 1'b0;
        clear_mon();
        start_run(5, 1);
        wait_valid("midrst", 50);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("midrst_tvalid", 32'(axis.tvalid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_index", 32'(index), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        ready_fix = 1'b1;
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
